mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Grants one transaction at a time, latches its payload, and drives the memory request until ack or timeout.
- Returns read data plus a one-cycle done/err pulse to the owner.
- Data has priority; a bounded streak counter prevents fetch starvation. Its done pulses feed the fetch-stall logic in the core controller.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
TIMEOUT, 255, max BUSY cycles waiting for mem_ack_i before error (>=1)
MAX_STREAK, 4, max consecutive D grants while I is pending (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
i_req_i  in  1  fetch request; held with i_addr_i stable until i_done_o
i_addr_i  in  ADDR_W  fetch address
i_rdata_o  out  DATA_W  fetch data, valid while i_done_o=1
i_done_o  out  1  one-cycle completion pulse to I
i_err_o  out  1  with i_done_o: transaction timed out
d_req_i  in  1  load/store request; payload held until d_done_o
d_we_i  in  1  1=store
d_be_i  in  DATA_W/8  byte enables
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_rdata_o  out  DATA_W  load data, valid while d_done_o=1
d_done_o  out  1  one-cycle completion pulse to D
d_err_o  out  1  with d_done_o: timed out
mem_req_o  out  1  memory request, high throughout BUSY
mem_we_o  out  1  latched write enable (0 for I)
mem_be_o  out  DATA_W/8  latched byte enables (all 1s for I)
mem_addr_o  out  ADDR_W  latched address
mem_wdata_o  out  DATA_W  latched write data (0 for I)
mem_ack_i  in  1  one-cycle completion from memory; mem_rdata_i valid same cycle
mem_rdata_i  in  DATA_W  read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; owner=I. Reset mid-transaction abandons it; no done pulse is issued, and mem_req_o is 0 from the cycle after the reset edge.
- FSM IDLE -> BUSY -> RESP -> IDLE. All outputs are registered or decoded directly from state/latched registers.
- IDLE: samples requests at the clock edge.
  - If d_req_i and NOT (i_req_i and streak==MAX_STREAK): grant D.
  - Else if i_req_i: grant I.
  - On grant: latch owner and payload, clear timeout counter, go BUSY.
- Streak counter:
  - D grant with i_req_i=1: streak+1, saturating at MAX_STREAK.
  - D grant with i_req_i=0: streak=0.
  - I grant: streak=0.
- BUSY: mem_req_o=1, with mem_* driven from latched payload (stable the whole state).
  - mem_ack_i=1: capture mem_rdata_i (store: capture 0), err=0, go RESP.
  - Else if tcount==TIMEOUT-1: rdata=0, err=1, go RESP.
  - Else tcount+1.
- RESP (exactly one cycle): owner's done_o=1, err_o=err, rdata_o=captured value.
  - Non-owner done/err are 0; both rdata outputs are 0 outside RESP.
  - Requests are not sampled in RESP. A requester may keep req high with a new payload for back-to-back issue.
- mem_ack_i outside BUSY (late ack after timeout) is ignored.
- Minimum transaction time with zero-wait memory: 3 cycles (grant edge, BUSY with ack, RESP).
- Payload changes by a requester after grant do not affect mem_* outputs.

Test Plan:
1. I only, addr 0x100, ack 2 cycles after mem_req_o rises, rdata 0xDEADBEEF -> i_done_o pulse 1 cycle with i_rdata_o=0xDEADBEEF, i_err_o=0; d_done_o stays 0.
2. I and D requested the same cycle (D store addr 0x2000, wdata 0x55AA, be 0011) -> D granted first with mem_we_o=1, mem_be_o=0011; I granted at the next IDLE.
3. D requests continuously, I pending, MAX_STREAK=4, zero-wait memory -> grants D,D,D,D,I; streak resets and D resumes.
4. TIMEOUT=8, D load, no ack -> mem_req_o high exactly 8 cycles, then d_done_o=1, d_err_o=1, d_rdata_o=0. An ack injected 2 cycles later produces no output change.
5. rst_n low during BUSY -> mem_req_o=0 and busy_o=0 next cycle, no done pulses; a fresh I request afterwards completes normally.
6. Back-to-back D loads with zero-wait memory -> d_done_o every 3rd cycle; mem_addr_o tracks each new address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// Data wins ties; a streak limit guarantees fetch eventually gets through.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic [DATA_W-1:0]   i_rdata_o,
    output logic                i_done_o,
    output logic                i_err_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_done_o,
    output logic                d_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int BE_W = DATA_W / 8;
    localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SK_W = $clog2(MAX_STREAK + 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);
    localparam logic [SK_W-1:0] SK_MAX  = SK_W'(MAX_STREAK);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;     // 1 = D owns the port
    logic              r_err;
    logic [SK_W-1:0]   r_streak;
    logic [TC_W-1:0]   r_tcount;
    logic              r_we;
    logic [BE_W-1:0]   r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic w_grant_d, w_grant_i, w_ack, w_tmo, w_busy, w_resp;

    always_comb begin
        w_grant_d = (r_state == S_IDLE) && d_req_i && !(i_req_i && (r_streak == SK_MAX));
        w_grant_i = (r_state == S_IDLE) && !w_grant_d && i_req_i;
        w_ack     = (r_state == S_BUSY) && mem_ack_i;
        w_tmo     = (r_state == S_BUSY) && !mem_ack_i && (r_tcount == TC_LAST);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_d || w_grant_i) w_next = S_BUSY;
            S_BUSY:  if (w_ack || w_tmo) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner  <= 1'b0;
            r_err    <= 1'b0;
            r_streak <= '0;
            r_tcount <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner  <= 1'b1;
                r_tcount <= '0;
                // Only count D wins that actually made a waiting fetch wait.
                if (!i_req_i)                r_streak <= '0;
                else if (r_streak != SK_MAX) r_streak <= r_streak + 1'b1;
            end else if (w_grant_i) begin
                r_owner  <= 1'b0;
                r_tcount <= '0;
                r_streak <= '0;
            end else if (r_state == S_BUSY && !w_ack && !w_tmo) begin
                r_tcount <= r_tcount + 1'b1;
            end
            if (w_ack)      r_err <= 1'b0;
            else if (w_tmo) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant_d) begin
            r_we    <= d_we_i;
            r_be    <= d_be_i;
            r_addr  <= d_addr_i;
            r_wdata <= d_wdata_i;
        end else if (w_grant_i) begin
            r_we    <= 1'b0;
            r_be    <= '1;
            r_addr  <= i_addr_i;
            r_wdata <= '0;
        end
        if (w_ack)      r_rdata <= r_we ? '0 : mem_rdata_i;
        else if (w_tmo) r_rdata <= '0;
    end

    // Everything below is decoded from state so reset forces all outputs low.
    assign w_busy      = (r_state == S_BUSY);
    assign w_resp      = (r_state == S_RESP);
    assign busy_o      = (r_state != S_IDLE);
    assign mem_req_o   = w_busy;
    assign mem_we_o    = w_busy & r_we;
    assign mem_be_o    = w_busy ? r_be    : '0;
    assign mem_addr_o  = w_busy ? r_addr  : '0;
    assign mem_wdata_o = w_busy ? r_wdata : '0;
    assign i_done_o    = w_resp & ~r_owner;
    assign d_done_o    = w_resp &  r_owner;
    assign i_err_o     = i_done_o & r_err;
    assign d_err_o     = d_done_o & r_err;
    assign i_rdata_o   = i_done_o ? r_rdata : '0;
    assign d_rdata_o   = d_done_o ? r_rdata : '0;

endmodule
